// File: rtl/full_pipe.sv
// Two-entry valid/ready slice: every output starts at a flop, one cycle of latency, full throughput.
// A slave stall parks the single in-flight payload in the skid register S; f_ready_out drops one cycle later.
module full_pipe #(
   parameter int DATA_W = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              f_valid_in,
   input  logic [DATA_W-1:0] f_data_in,
   output logic              f_ready_out,
   output logic              b_valid_out,
   output logic [DATA_W-1:0] b_data_out,
   input  logic              b_ready_in,
   input  logic              flush,
   output logic [1:0]        count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_vld;
   logic              r_rdy;
   logic [1:0]        r_count;
   logic [DATA_W-1:0] r_m;
   logic [DATA_W-1:0] r_s;

   logic              w_in;
   logic              w_out;
   logic              w_load_m_in;
   logic              w_load_m_s;
   logic              w_load_s;

   assign w_in  = f_valid_in & r_rdy;
   assign w_out = r_vld & b_ready_in;

   always_comb begin
      w_state_nxt = r_state;
      w_load_m_in = 1'b0;
      w_load_m_s  = 1'b0;
      w_load_s    = 1'b0;
      case (r_state)
         EMPTY: begin
            if (w_in) begin
               w_load_m_in = 1'b1;
               w_state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (w_in && w_out) begin
               w_load_m_in = 1'b1;
            end else if (w_in) begin
               w_load_s    = 1'b1;
               w_state_nxt = FULL;
            end else if (w_out) begin
               w_state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (w_out) begin
               w_load_m_s  = 1'b1;
               w_state_nxt = BUSY;
            end
         end
         default: begin
            w_state_nxt = EMPTY;
         end
      endcase
      // Flush wins over everything; payload registers keep their stale contents.
      if (flush) begin
         w_state_nxt = EMPTY;
         w_load_m_in = 1'b0;
         w_load_m_s  = 1'b0;
         w_load_s    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= EMPTY;
         r_vld   <= 1'b0;
         r_rdy   <= 1'b1;
         r_count <= 2'd0;
      end else begin
         r_state <= w_state_nxt;
         r_vld   <= (w_state_nxt != EMPTY);
         r_rdy   <= (w_state_nxt != FULL);
         r_count <= (w_state_nxt == FULL) ? 2'd2 : (w_state_nxt == BUSY) ? 2'd1 : 2'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m <= '0;
         r_s <= '0;
      end else begin
         if (w_load_m_in) begin
            r_m <= f_data_in;
         end else if (w_load_m_s) begin
            r_m <= r_s;
         end
         if (w_load_s) begin
            r_s <= f_data_in;
         end
      end
   end

   assign f_ready_out = r_rdy;
   assign b_valid_out = r_vld;
   assign b_data_out  = r_m;
   assign count       = r_count;

endmodule

// File: tb/tb_full_pipe.sv
// Directed and random-backpressure bench for full_pipe with a reference queue scoreboard.
module tb_full_pipe;

   localparam int DW = 256;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          f_valid_in;
   logic [DW-1:0] f_data_in;
   logic          f_ready_out;
   logic          b_valid_out;
   logic [DW-1:0] b_data_out;
   logic          b_ready_in;
   logic          flush;
   logic [1:0]    count;

   int n_chk = 0;
   int n_err = 0;
   int n_acc = 0;
   logic [DW-1:0] q[$];

   full_pipe #(.DATA_W(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .f_valid_in (f_valid_in),
      .f_data_in  (f_data_in),
      .f_ready_out(f_ready_out),
      .b_valid_out(b_valid_out),
      .b_data_out (b_data_out),
      .b_ready_in (b_ready_in),
      .flush      (flush),
      .count      (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Drive one cycle from the post-edge sampling point, update the reference queue, step one edge.
   task automatic cycle(input logic vin, input logic [DW-1:0] din, input logic rin, input logic fl);
      logic          hs_in;
      logic          hs_out;
      logic          stall;
      logic [DW-1:0] held;
      f_valid_in = vin;
      f_data_in  = din;
      b_ready_in = rin;
      flush      = fl;
      hs_in  = vin & f_ready_out;
      hs_out = b_valid_out & rin;
      stall  = b_valid_out & ~rin & ~fl;
      held   = b_data_out;
      if (hs_out && q.size() > 0) chk("sb_order", b_data_out, q.pop_front());
      if (hs_in) begin
         q.push_back(din);
         n_acc++;
      end
      if (fl) q.delete();
      @(posedge clk);
      #1;
      chk("occ", {254'd0, count}, q.size());
      chk("vld", {255'd0, b_valid_out}, {255'd0, q.size() != 0});
      chk("rdy", {255'd0, f_ready_out}, {255'd0, q.size() < 2});
      if (stall) chk("stable", b_data_out, held);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_vld"}, {255'd0, b_valid_out}, '0);
      chk({tag, "_rdy"}, {255'd0, f_ready_out}, 256'd1);
      chk({tag, "_cnt"}, {254'd0, count}, '0);
      chk({tag, "_dat"}, b_data_out, '0);
   endtask

   initial begin
      int guard;
      rst_n      = 1'b0;
      f_valid_in = 1'b0;
      f_data_in  = '0;
      b_ready_in = 1'b0;
      flush      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("rst");
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, '0, 1'b0, 1'b0);
         chk_reset_vals("idle");
      end

      // Back-to-back stream with the slave always ready
      for (int v = 1; v <= 32; v++) begin
         cycle(1'b1, DW'(v), 1'b1, 1'b0);
         chk("stream_dat", b_data_out, DW'(v));
         chk("stream_cnt", {254'd0, count}, 256'd1);
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
      chk("stream_drain", {255'd0, b_valid_out}, '0);

      // Stall absorption: slave drops ready while 0xB is accepted
      cycle(1'b1, DW'('hA), 1'b1, 1'b0);
      chk("stall_a", b_data_out, DW'('hA));
      cycle(1'b1, DW'('hB), 1'b0, 1'b0);
      chk("stall_cnt2", {254'd0, count}, 256'd2);
      chk("stall_rdy0", {255'd0, f_ready_out}, '0);
      chk("stall_hold_a", b_data_out, DW'('hA));
      cycle(1'b1, DW'('hC), 1'b1, 1'b0);
      chk("stall_b", b_data_out, DW'('hB));
      chk("stall_b_vld", {255'd0, b_valid_out}, 256'd1);
      chk("stall_rdy1", {255'd0, f_ready_out}, 256'd1);
      cycle(1'b1, DW'('hC), 1'b1, 1'b0);
      chk("stall_c", b_data_out, DW'('hC));
      chk("stall_c_vld", {255'd0, b_valid_out}, 256'd1);
      cycle(1'b0, '0, 1'b1, 1'b0);
      chk("stall_empty", {254'd0, count}, '0);

      // Flush from FULL while the master offers 0x77
      cycle(1'b1, DW'('h55), 1'b0, 1'b0);
      cycle(1'b1, DW'('h66), 1'b0, 1'b0);
      chk("flush_pre_cnt", {254'd0, count}, 256'd2);
      cycle(1'b1, DW'('h77), 1'b0, 1'b1);
      chk("flush_cnt", {254'd0, count}, '0);
      chk("flush_vld", {255'd0, b_valid_out}, '0);
      chk("flush_rdy", {255'd0, f_ready_out}, 256'd1);
      chk("flush_m_kept", b_data_out, DW'('h55));
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, '0, 1'b1, 1'b0);
         chk("flush_no77", {255'd0, b_valid_out}, '0);
      end
      // Flush from BUSY with both handshakes live: accepted payload is discarded
      cycle(1'b1, DW'('h11), 1'b0, 1'b0);
      cycle(1'b1, DW'('h88), 1'b1, 1'b1);
      chk("flush2_vld", {255'd0, b_valid_out}, '0);
      chk("flush2_m_kept", b_data_out, DW'('h11));

      // Asynchronous reset while FULL
      cycle(1'b1, DW'('h21), 1'b0, 1'b0);
      cycle(1'b1, DW'('h22), 1'b0, 1'b0);
      chk("mrst_pre_cnt", {254'd0, count}, 256'd2);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("mrst");
      q.delete();
      f_valid_in = 1'b1;
      f_data_in  = DW'('hEE);
      b_ready_in = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("mrst_hold");
      f_valid_in = 1'b0;
      rst_n = 1'b1;
      cycle(1'b1, DW'('h99), 1'b0, 1'b0);
      chk("mrst_99", b_data_out, DW'('h99));
      chk("mrst_99_vld", {255'd0, b_valid_out}, 256'd1);
      cycle(1'b0, '0, 1'b1, 1'b0);

      // Random traffic against the reference queue
      n_acc = 0;
      guard = 0;
      while (n_acc < 10000 && guard < 60000) begin
         cycle(1'($urandom_range(0, 1)),
               {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()},
               1'($urandom_range(0, 1)), 1'b0);
         chk("rand_cnt_max", {255'd0, count > 2'd2}, '0);
         guard++;
      end
      chk("rand_accepted", {255'd0, n_acc >= 10000}, 256'd1);
      guard = 0;
      while (q.size() > 0 && guard < 10) begin
         cycle(1'b0, '0, 1'b1, 1'b0);
         guard++;
      end
      chk("rand_drained", {255'd0, b_valid_out}, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/full_pipe.md
# full_pipe

Two-entry pipeline register slice that registers both the forward path (valid/data) and the backward path (ready) of a valid/ready stream. It complements the existing ready-only backward slice: this block cuts every combinational path between master and slave, at one cycle of latency and full throughput. It is inserted on long or congested routes between NPU submodules where both the data/valid cone and the ready cone must start at a flop.

## Interface
- DATA_W, 256, payload width in bits.

- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- f_valid_in  input  1  master valid.
- f_data_in  input  DATA_W  master payload.
- f_ready_out  output  1  ready to master; driven directly from a flop.
- b_valid_out  output  1  valid to slave; driven directly from a flop.
- b_data_out  output  DATA_W  payload to slave; driven directly from the main data register.
- b_ready_in  input  1  slave ready.
- flush  input  1  synchronous discard of all held entries.
- count  output  2  occupancy: 0, 1 or 2.

## Operation
- Storage: main register M (drives b_data_out) and skid register S.
- State machine with states EMPTY (count 0), BUSY (count 1, M valid), FULL (count 2, M and S valid).
- Outputs per state: b_valid_out = (state != EMPTY); f_ready_out = (state != FULL). Both are held in dedicated flops updated with the next state, never decoded combinationally from inputs.
- Handshakes: in = f_valid_in & f_ready_out; out = b_valid_out & b_ready_in.
- EMPTY: in -> M <= f_data_in, go to BUSY. Otherwise stay.
- BUSY:
  - in & out -> M <= f_data_in, stay in BUSY.
  - in & ~out -> S <= f_data_in, go to FULL.
  - ~in & out -> go to EMPTY.
  - Neither -> hold.
- FULL: no input can be accepted because f_ready_out = 0.
  - out -> M <= S, go to BUSY.
  - Otherwise hold.
- Ordering: strict FIFO order; payloads leave in acceptance order, with none duplicated or dropped (except on flush).
- flush has priority over every transition:
  - Next state is EMPTY; count goes to 0, b_valid_out to 0, f_ready_out to 1.
  - Any in or out handshake in the flush cycle is still a handshake from the master's or slave's view, but its payload is discarded.
  - M and S keep their contents; they are don't-care while invalid.
- b_data_out and M, S change only on the loads listed above. b_data_out is stable while b_valid_out = 1 and b_ready_in = 0.
- Payload is never inspected; there are no width conversions.

## Timing
- Reset values (asynchronous, applied immediately on rst_n low):
  - State EMPTY, b_valid_out 0, f_ready_out 1, count 0.
  - M and S cleared to 0, so b_data_out = 0.
- Inputs sampled while rst_n is low are ignored. Reset asserted mid-transfer drops all held entries with no partial output.
- Latency: a payload accepted at edge N is presented on b_data_out with b_valid_out = 1 after edge N (one cycle).
- Throughput: one transfer per cycle sustained while b_ready_in = 1. f_ready_out stays 1 in BUSY.
- Backpressure:
  - A slave stall is visible to the master as f_ready_out = 0 only one cycle later.
  - The single payload accepted during that cycle is absorbed by S. No payload loss for any ready pattern.
- FULL to BUSY: f_ready_out rises the cycle after the slave consumes M. New input is accepted from that cycle on.
- Combinational paths: none from any input to any output.

## Test plan
- Reset and idle: hold rst_n low, then release with all inputs 0 -> b_valid_out 0, f_ready_out 1, count 0, b_data_out 0 for 10 cycles.
- Streaming:
  - Stimulus: b_ready_in = 1, master drives 0x1..0x20 back-to-back.
  - Required: each value appears one cycle after acceptance, in order, one per cycle; count stays 1 during the stream.
- Stall absorption:
  - Stimulus: stream 0xA, 0xB, 0xC with b_ready_in dropped in the cycle 0xB is accepted.
  - Required: count reaches 2 and f_ready_out = 0 next cycle. On b_ready_in = 1, output is 0xA, 0xB, 0xC with no gap after the stall clears.
- Random backpressure: 10k random payloads with random f_valid_in and b_ready_in (50% each) -> scoreboard exact order match; count never exceeds 2; b_data_out is stable whenever valid and not ready.
- Flush:
  - Stimulus: fill to count 2 with 0x55 and 0x66, pulse flush with f_valid_in = 1 carrying 0x77.
  - Required: the next cycle shows count 0, b_valid_out 0, f_ready_out 1, and 0x77 never appears at the output.
- Mid-operation reset: assert rst_n low while in FULL -> outputs immediately at reset values; after release, a new payload 0x99 emerges with one-cycle latency.
